// File: rtl/bfm_ahb_pkg.sv
// -----------------------------------------------------------------------------
// bfm_ahb_pkg
// Shared AHB definitions for the bus-functional arbiter:
//   - HTRANS and HBURST encodings
//   - arbiter state encoding
//   - burst-length lookup (remaining beats after the NONSEQ beat)
//   - one-hot to index helper sized for the largest supported master count
// -----------------------------------------------------------------------------
package bfm_ahb_pkg;

    localparam int MAX_MASTERS = 4;
    localparam int MIDX_W      = 2;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR   = 3'b001,
        HBURST_WRAP4  = 3'b010,
        HBURST_INCR4  = 3'b011,
        HBURST_WRAP8  = 3'b100,
        HBURST_INCR8  = 3'b101,
        HBURST_WRAP16 = 3'b110,
        HBURST_INCR16 = 3'b111
    } hburst_t;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'b00,  // default master parked, nobody requesting
        ARB_OWNED  = 2'b01,  // single / undefined-length INCR traffic
        ARB_BURST  = 2'b10,  // fixed-length burst still has beats to go
        ARB_LOCKED = 2'b11   // address phase is a locked sequence
    } arb_state_t;

    // Beats still to come after the NONSEQ beat. SINGLE and INCR return 0:
    // an undefined-length burst gets no protection from the counter.
    function automatic logic [3:0] burst_beats(input hburst_t burst);
        logic [3:0] beats;
        case (burst)
            HBURST_WRAP4,  HBURST_INCR4:  beats = 4'd3;
            HBURST_WRAP8,  HBURST_INCR8:  beats = 4'd7;
            HBURST_WRAP16, HBURST_INCR16: beats = 4'd15;
            default:                      beats = 4'd0;
        endcase
        return beats;
    endfunction

    function automatic logic [MIDX_W-1:0] onehot_to_idx(input logic [MAX_MASTERS-1:0] oh);
        logic [MIDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_MASTERS; i++) begin
            if (oh[i]) idx = MIDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/bfm_rrpick.sv
// -----------------------------------------------------------------------------
// bfm_rrpick
// Combinational round-robin picker. The search starts at the master after
// `last` and wraps; the first requester wins. With no requester the
// DEFAULT_IDX master is returned, so the result is always one-hot.
// Ports:
//   req    [NMASTER-1:0]  in   request vector
//   last   [MIDX_W-1:0]   in   previous owner (search starts at last+1)
//   winner [NMASTER-1:0]  out  one-hot winner
// -----------------------------------------------------------------------------
module bfm_rrpick
    import bfm_ahb_pkg::*;
#(
    parameter int NMASTER     = 4,
    parameter int DEFAULT_IDX = 0
) (
    input  logic [NMASTER-1:0] req,
    input  logic [MIDX_W-1:0]  last,
    output logic [NMASTER-1:0] winner
);

    localparam int IW = (NMASTER > 1) ? $clog2(NMASTER) : 1;

    logic [IW-1:0] idx;
    logic          found;

    // NOTE: every variable written here gets a default first, otherwise a
    // path that skips the assignment would infer a latch.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 1; k <= NMASTER; k++) begin
            idx = IW'((int'(last) + k) % NMASTER);
            if (!found && req[idx]) begin
                winner[idx] = 1'b1;
                found       = 1'b1;
            end
        end
        if (!found) winner[DEFAULT_IDX] = 1'b1;
    end

endmodule

// File: rtl/bfm_ahbarbiter.sv
// -----------------------------------------------------------------------------
// bfm_ahbarbiter
// AHB bus arbiter: round-robin grant with fixed-length burst protection,
// locked-transfer hold and early re-arbitration on ERROR.
// Ports:
//   HCLK                    in   bus clock
//   HRESET                  in   asynchronous reset, active-high
//   HBUSREQ  [NMASTER-1:0]  in   per-master bus request
//   HLOCK    [NMASTER-1:0]  in   per-master locked-transfer request
//   HTRANS   [1:0]          in   address-phase transfer type of the owner
//   HBURST   [2:0]          in   address-phase burst type of the owner
//   HREADY                  in   bus-wide transfer complete
//   HRESP                   in   slave response, 1 = ERROR
//   HGRANT   [NMASTER-1:0]  out  one-hot grant (next owner)
//   HMASTER  [1:0]          out  index of the address-phase owner
//   HMASTLOCK               out  current address phase is locked
// TPD is carried so behavioural-model instantiations elaborate unchanged;
// no output delay is modelled in this synthesizable view.
// -----------------------------------------------------------------------------
module bfm_ahbarbiter
    import bfm_ahb_pkg::*;
#(
    parameter int NMASTER   = 4,
    parameter int DEFMASTER = 0,
    parameter int TPD       = 1
) (
    input  logic               HCLK,
    input  logic               HRESET,
    input  logic [NMASTER-1:0] HBUSREQ,
    input  logic [NMASTER-1:0] HLOCK,
    input  logic [1:0]         HTRANS,
    input  logic [2:0]         HBURST,
    input  logic               HREADY,
    input  logic               HRESP,
    output logic [NMASTER-1:0] HGRANT,
    output logic [1:0]         HMASTER,
    output logic               HMASTLOCK
);

    if (NMASTER < 2 || NMASTER > MAX_MASTERS || DEFMASTER < 0 ||
        DEFMASTER >= NMASTER || TPD < 0) begin : g_bad_params
        $error("bfm_ahbarbiter: illegal NMASTER/DEFMASTER/TPD");
    end

    localparam logic [NMASTER-1:0] DEF_GRANT = NMASTER'(1) << DEFMASTER;

    htrans_t                htrans;
    hburst_t                hburst;
    logic [MAX_MASTERS-1:0] lock_ext;
    logic [NMASTER-1:0]     hgrant;
    logic [NMASTER-1:0]     pick;
    logic [MIDX_W-1:0]      hmaster;
    logic [MIDX_W-1:0]      grant_idx;
    logic [3:0]             beats_left;
    logic [3:0]             beats_next;
    logic [3:0]             load_beats;
    arb_state_t             state;
    logic                   lock_hold;
    logic                   count_done;
    logic                   load_closes;
    logic                   arb_open;

    assign htrans    = htrans_t'(HTRANS);
    assign hburst    = hburst_t'(HBURST);
    // Widened so a 2-bit master index can address it for any NMASTER.
    assign lock_ext  = MAX_MASTERS'(HLOCK);
    assign grant_idx = onehot_to_idx(MAX_MASTERS'(hgrant));

    // Beat counter next value for an HREADY=1 edge.
    always_comb begin
        load_beats = burst_beats(hburst);
        beats_next = beats_left;
        case (htrans)
            HTRANS_NONSEQ: beats_next = load_beats;
            HTRANS_SEQ:    if (beats_left != 4'd0) beats_next = beats_left - 4'd1;
            default:       beats_next = beats_left;
        endcase
    end

    // Arbitration window. The last beat of a burst (count 1 with SEQ on the
    // bus) already opens it so the next owner is granted in time. A NONSEQ
    // that loads a non-zero count closes it in the same cycle, otherwise
    // the grant could slip away just as a burst starts.
    assign lock_hold   = (state == ARB_LOCKED) && lock_ext[hmaster];
    assign count_done  = (beats_left == 4'd0) ||
                         ((beats_left == 4'd1) && (htrans == HTRANS_SEQ));
    assign load_closes = (htrans == HTRANS_NONSEQ) && (load_beats != 4'd0);
    assign arb_open    = !lock_hold && count_done && !load_closes;

    bfm_rrpick #(
        .NMASTER     (NMASTER),
        .DEFAULT_IDX (DEFMASTER)
    ) u_rrpick (
        .req    (HBUSREQ),
        .last   (hmaster),
        .winner (pick)
    );

    // NOTE: state is updated with non-blocking assignments so every term
    // above sees the pre-edge values, regardless of statement order.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            hgrant     <= DEF_GRANT;
            hmaster    <= MIDX_W'(DEFMASTER);
            beats_left <= 4'd0;
            state      <= ARB_IDLE;
        end else if (HREADY) begin
            hmaster    <= grant_idx;
            beats_left <= beats_next;
            if (arb_open) hgrant <= pick;

            if (lock_ext[grant_idx])    state <= ARB_LOCKED;
            else if (beats_next != 4'd0) state <= ARB_BURST;
            else if (|HBUSREQ)           state <= ARB_OWNED;
            else                         state <= ARB_IDLE;
        end else if (HRESP) begin
            // First ERROR cycle: drop the rest of the burst so the second
            // ERROR cycle (HREADY=1) can re-arbitrate.
            beats_left <= 4'd0;
        end
    end

    assign HGRANT    = hgrant;
    assign HMASTER   = hmaster;
    assign HMASTLOCK = (state == ARB_LOCKED);

endmodule

// File: tb/tb_bfm_ahbarbiter.sv
// -----------------------------------------------------------------------------
// tb_bfm_ahbarbiter
// Directed bench for bfm_ahbarbiter (NMASTER=4, DEFMASTER=0). Each step
// drives one bus cycle, pushes the outputs expected after the next HCLK edge
// onto a scoreboard, and pops/compares them 1 ns after that edge.
// -----------------------------------------------------------------------------
module tb_bfm_ahbarbiter;

    localparam logic [1:0] T_IDLE = 2'b00, T_NSQ = 2'b10, T_SEQ = 2'b11;
    localparam logic [2:0] B_SGL = 3'd0, B_INCR4 = 3'd3, B_INCR8 = 3'd5,
                           B_WRAP16 = 3'd6, B_INCR16 = 3'd7;

    logic       HCLK, HRESET, HREADY, HRESP;
    logic [3:0] HBUSREQ, HLOCK, HGRANT;
    logic [1:0] HTRANS, HMASTER;
    logic [2:0] HBURST;
    logic       HMASTLOCK;

    typedef struct {
        string      tag;
        logic [3:0] grant;
        logic [1:0] master;
        logic       lock;
        int         bl;      // expected beats_left, -1 = not checked
    } exp_t;

    exp_t sb[$];
    int   total  = 0;
    int   passed = 0;
    int   failed = 0;

    bfm_ahbarbiter #(.NMASTER(4), .DEFMASTER(0), .TPD(1)) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .HBUSREQ   (HBUSREQ),
        .HLOCK     (HLOCK),
        .HTRANS    (HTRANS),
        .HBURST    (HBURST),
        .HREADY    (HREADY),
        .HRESP     (HRESP),
        .HGRANT    (HGRANT),
        .HMASTER   (HMASTER),
        .HMASTLOCK (HMASTLOCK)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [3:0] g, input logic [1:0] m,
                              input logic l, input int bl);
        exp_t e;
        e.tag = tag; e.grant = g; e.master = m; e.lock = l; e.bl = bl;
        sb.push_back(e);
    endtask

    task automatic compare_next();
        exp_t e;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({e.tag, ".HGRANT"},    32'(HGRANT),    32'(e.grant));
            check({e.tag, ".HMASTER"},   32'(HMASTER),   32'(e.master));
            check({e.tag, ".HMASTLOCK"}, 32'(HMASTLOCK), 32'(e.lock));
            if (e.bl >= 0) check({e.tag, ".beats_left"}, 32'(dut.beats_left), 32'(e.bl));
        end
    endtask

    // One bus cycle: drive, queue the post-edge expectation, compare after edge.
    task automatic cyc(input string tag, input logic [3:0] req, input logic [3:0] lock,
                       input logic [1:0] trans, input logic [2:0] burst,
                       input logic rdy, input logic resp,
                       input logic [3:0] eg, input logic [1:0] em, input logic el, input int ebl);
        HBUSREQ = req; HLOCK = lock; HTRANS = trans; HBURST = burst;
        HREADY = rdy; HRESP = resp;
        expect_out(tag, eg, em, el, ebl);
        @(posedge HCLK);
        #1;
        compare_next();
    endtask

    initial begin
        HRESET = 1'b1; HBUSREQ = '0; HLOCK = '0; HTRANS = T_IDLE;
        HBURST = B_SGL; HREADY = 1'b1; HRESP = 1'b0;

        // Reset values, before and across clock edges.
        #2;
        expect_out("reset", 4'b0001, 2'd0, 1'b0, 0);
        compare_next();
        @(posedge HCLK); @(posedge HCLK); #1;
        expect_out("reset_hold", 4'b0001, 2'd0, 1'b0, 0);
        compare_next();
        #4 HRESET = 1'b0;

        // Idle bus: default master stays parked.
        for (int i = 0; i < 3; i++)
            cyc("idle", 4'b0000, 4'b0000, T_IDLE, B_SGL, 1, 0, 4'b0001, 2'd0, 0, 0);

        // Round-robin, everyone requesting single transfers. The search
        // starts after HMASTER, which trails HGRANT by one edge.
        cyc("rr1",  4'b1111, 4'b0, T_NSQ, B_SGL, 1, 0, 4'b0010, 2'd0, 0, 0);
        cyc("rr2",  4'b1111, 4'b0, T_NSQ, B_SGL, 1, 0, 4'b0010, 2'd1, 0, 0);
        cyc("rr3",  4'b1111, 4'b0, T_NSQ, B_SGL, 1, 0, 4'b0100, 2'd1, 0, 0);
        cyc("rr4",  4'b1111, 4'b0, T_NSQ, B_SGL, 1, 0, 4'b0100, 2'd2, 0, 0);
        cyc("rr5",  4'b1111, 4'b0, T_NSQ, B_SGL, 1, 0, 4'b1000, 2'd2, 0, 0);
        cyc("rr6",  4'b1111, 4'b0, T_NSQ, B_SGL, 1, 0, 4'b1000, 2'd3, 0, 0);
        cyc("rr7",  4'b1111, 4'b0, T_NSQ, B_SGL, 1, 0, 4'b0001, 2'd3, 0, 0);
        cyc("rr8",  4'b1111, 4'b0, T_NSQ, B_SGL, 1, 0, 4'b0001, 2'd0, 0, 0);
        cyc("rr9",  4'b1111, 4'b0, T_NSQ, B_SGL, 1, 0, 4'b0010, 2'd0, 0, 0);
        cyc("rr10", 4'b1111, 4'b0, T_NSQ, B_SGL, 1, 0, 4'b0010, 2'd1, 0, 0);

        // INCR8 on M1 while M2 requests: grant held for 8 beats.
        cyc("incr8_nsq", 4'b0110, 4'b0, T_NSQ, B_INCR8, 1, 0, 4'b0010, 2'd1, 0, 7);
        for (int b = 6; b >= 1; b--)
            cyc("incr8_seq", 4'b0110, 4'b0, T_SEQ, B_INCR8, 1, 0, 4'b0010, 2'd1, 0, b);
        cyc("incr8_last", 4'b0110, 4'b0, T_SEQ, B_INCR8, 1, 0, 4'b0100, 2'd1, 0, 0);
        cyc("incr8_post", 4'b0100, 4'b0, T_IDLE, B_SGL, 1, 0, 4'b0100, 2'd2, 0, 0);

        // INCR4 on M2 with three wait states on beat 2; M0 waits.
        cyc("incr4_nsq",  4'b0101, 4'b0, T_NSQ, B_INCR4, 1, 0, 4'b0100, 2'd2, 0, 3);
        cyc("incr4_b2",   4'b0101, 4'b0, T_SEQ, B_INCR4, 1, 0, 4'b0100, 2'd2, 0, 2);
        for (int w = 0; w < 3; w++)
            cyc("incr4_wait", 4'b0101, 4'b0, T_SEQ, B_INCR4, 0, 0, 4'b0100, 2'd2, 0, 2);
        cyc("incr4_b3",   4'b0101, 4'b0, T_SEQ, B_INCR4, 1, 0, 4'b0100, 2'd2, 0, 1);
        cyc("incr4_b4",   4'b0101, 4'b0, T_SEQ, B_INCR4, 1, 0, 4'b0001, 2'd2, 0, 0);

        // Locked sequence by M3 while M0 keeps requesting.
        cyc("lock_gnt",  4'b1001, 4'b1000, T_IDLE, B_SGL, 1, 0, 4'b1000, 2'd0, 0, 0);
        cyc("lock_own",  4'b1001, 4'b1000, T_IDLE, B_SGL, 1, 0, 4'b1000, 2'd3, 1, 0);
        for (int t = 0; t < 3; t++)
            cyc("lock_xfer", 4'b1001, 4'b1000, T_NSQ, B_SGL, 1, 0, 4'b1000, 2'd3, 1, 0);
        cyc("lock_idle", 4'b1001, 4'b1000, T_IDLE, B_SGL, 1, 0, 4'b1000, 2'd3, 1, 0);
        cyc("unlock_wait", 4'b1001, 4'b0000, T_IDLE, B_SGL, 0, 0, 4'b1000, 2'd3, 1, 0);
        cyc("unlock",    4'b1001, 4'b0000, T_IDLE, B_SGL, 1, 0, 4'b0001, 2'd3, 0, 0);
        cyc("unlock_m0", 4'b0001, 4'b0000, T_IDLE, B_SGL, 1, 0, 4'b0001, 2'd0, 0, 0);

        // WRAP16 on M0 with ERROR on beat 3; M1 waits.
        cyc("wrap16_nsq", 4'b0011, 4'b0, T_NSQ, B_WRAP16, 1, 0, 4'b0001, 2'd0, 0, 15);
        cyc("wrap16_b2",  4'b0011, 4'b0, T_SEQ, B_WRAP16, 1, 0, 4'b0001, 2'd0, 0, 14);
        cyc("wrap16_b3",  4'b0011, 4'b0, T_SEQ, B_WRAP16, 1, 0, 4'b0001, 2'd0, 0, 13);
        cyc("err1",       4'b0011, 4'b0, T_SEQ, B_WRAP16, 0, 1, 4'b0001, 2'd0, 0, 0);
        cyc("err2",       4'b0011, 4'b0, T_IDLE, B_SGL,   1, 1, 4'b0010, 2'd0, 0, 0);
        cyc("err_post",   4'b0011, 4'b0, T_IDLE, B_SGL,   1, 0, 4'b0010, 2'd1, 0, 0);

        // Locked INCR16 on M1, then reset mid-burst between clock edges.
        cyc("incr16_nsq", 4'b0011, 4'b0010, T_NSQ, B_INCR16, 1, 0, 4'b0010, 2'd1, 1, 15);
        cyc("incr16_b2",  4'b0011, 4'b0010, T_SEQ, B_INCR16, 1, 0, 4'b0010, 2'd1, 1, 14);
        #3 HRESET = 1'b1;
        expect_out("async_reset", 4'b0001, 2'd0, 1'b0, 0);
        #1;
        compare_next();
        cyc("reset_held", 4'b0011, 4'b0010, T_SEQ, B_INCR16, 1, 0, 4'b0001, 2'd0, 0, 0);
        HRESET = 1'b0;

        // First grant change only on an HREADY=1 edge after reset release.
        cyc("post_rst_wait", 4'b0010, 4'b0, T_IDLE, B_SGL, 0, 0, 4'b0001, 2'd0, 0, 0);
        cyc("post_rst_gnt",  4'b0010, 4'b0, T_IDLE, B_SGL, 1, 0, 4'b0010, 2'd0, 0, 0);
        cyc("post_rst_own",  4'b0010, 4'b0, T_IDLE, B_SGL, 1, 0, 4'b0010, 2'd1, 0, 0);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
